// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int UART_SAMPLE_DEF    = 16;
    localparam int UART_DATA_BITS_DEF = 8;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for asynchronous inputs; both stages reset to 1 (idle line level).
module uart_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // NOTE: flops use non-blocking assignments so each stage samples the pre-edge value of the previous one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: centre-samples start/data/parity/stop on the oversampling tick
// and hands each frame to a one-entry valid/ready buffer with error and overrun status.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS_DEF,
    parameter int SAMPLE     = UART_SAMPLE_DEF,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = $clog2(SAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_MID = TW'(SAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(SAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          ODD      = (PARITY_ODD != 0);

    logic                 w_rx_s;
    rx_state_t            r_state;
    rx_state_t            w_next_state;
    logic                 w_commit;
    logic                 w_mid;
    logic                 w_end;
    logic [TW-1:0]        r_tick_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr_out;
    logic                 r_perr_out;
    logic                 r_overrun;

    uart_sync #(.WIDTH(1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    assign w_mid = (r_tick_cnt == TICK_MID);
    assign w_end = (r_tick_cnt == TICK_END);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_commit     = 1'b0;
        if (sample_tick) begin
            case (r_state)
                IDLE:   if (!w_rx_s) w_next_state = START;
                START:  if (w_mid) w_next_state = w_rx_s ? IDLE : DATA;
                DATA:   if (w_end && r_bit_cnt == BIT_LAST)
                            w_next_state = (PARITY_EN != 0) ? PARITY : STOP;
                PARITY: if (w_end) w_next_state = STOP;
                STOP:   if (w_end) begin
                            w_next_state = IDLE;
                            w_commit     = 1'b1;
                        end
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_perr     <= 1'b0;
        end else if (sample_tick) begin
            case (r_state)
                IDLE: r_tick_cnt <= '0;
                START: begin
                    if (w_mid) begin
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_end) begin
                        r_tick_cnt <= '0;
                        r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt != BIT_LAST) r_bit_cnt <= r_bit_cnt + 1'b1;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (w_end) begin
                        r_tick_cnt <= '0;
                        r_perr     <= (((^r_shift) ^ w_rx_s) != ODD);
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_end) r_tick_cnt <= '0;
                    else       r_tick_cnt <= r_tick_cnt + 1'b1;
                end
                default: r_tick_cnt <= '0;
            endcase
        end
    end

    // A commit lands only if the slot is empty or being drained in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_ferr_out <= 1'b0;
            r_perr_out <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_commit) begin
                if (!r_valid || rx_ready) begin
                    r_data     <= r_shift;
                    r_ferr_out <= ~w_rx_s;
                    r_perr_out <= r_perr;
                    r_valid    <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data    = r_data;
    assign rx_valid   = r_valid;
    assign frame_err  = r_ferr_out;
    assign parity_err = r_perr_out;
    assign overrun    = r_overrun;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: an 8N1 instance and an 8E1 instance share clock and tick.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_tick;
    logic       rx0, rx1, rdy0, rdy1;
    logic [7:0] d0, d1;
    logic       v0, v1, fe0, fe1, pe0, pe1, ov0, ov1, b0, b1;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DATA_BITS(8), .SAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .rx(rx0),
        .rx_data(d0), .rx_valid(v0), .rx_ready(rdy0), .frame_err(fe0),
        .parity_err(pe0), .overrun(ov0), .busy(b0)
    );

    uart_rx_ctrl #(.DATA_BITS(8), .SAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .rx(rx1),
        .rx_data(d1), .rx_valid(v1), .rx_ready(rdy1), .frame_err(fe1),
        .parity_err(pe1), .overrun(ov1), .busy(b1)
    );

    logic       sel = 1'b0;
    wire        cur_valid = sel ? v1  : v0;
    wire  [7:0] cur_data  = sel ? d1  : d0;
    wire        cur_ferr  = sel ? fe1 : fe0;
    wire        cur_perr  = sel ? pe1 : pe0;
    wire        cur_busy  = sel ? b1  : b0;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   ovr_cnt0 = 0;
    logic tick_at_edge = 1'b0;

    always @(posedge clk) begin
        tick_at_edge <= sample_tick;
        if (ov0) ovr_cnt0 <= ovr_cnt0 + 1;
    end

    // One tick every 4 clocks, changed on the falling edge.
    initial begin
        sample_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive_rx(input logic s, input logic b);
        if (s) rx1 = b;
        else   rx0 = b;
    endtask

    // Drives one frame bit-by-bit (64 clk per bit) and captures the buffer at the rx_valid rise.
    task automatic send_frame(input logic s, input logic [7:0] data, input logic par_en,
                              input logic par_bit, input logic stop_bit,
                              output logic rose, output logic tick_ok, output logic [7:0] cap_d,
                              output logic cap_fe, output logic cap_pe, output logic v_next);
        logic v_before;
        logic grab_next;
        sel = s;
        rose = 1'b0; tick_ok = 1'b0; cap_d = '0; cap_fe = 1'b0; cap_pe = 1'b0; v_next = 1'b0;
        grab_next = 1'b0;
        @(negedge clk);
        drive_rx(s, 1'b0);
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive_rx(s, data[i]);
            repeat (64) @(negedge clk);
        end
        if (par_en) begin
            drive_rx(s, par_bit);
            repeat (64) @(negedge clk);
        end
        drive_rx(s, stop_bit);
        v_before = cur_valid;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (grab_next) begin
                v_next    = cur_valid;
                grab_next = 1'b0;
            end
            if (!rose && cur_valid && !v_before) begin
                rose      = 1'b1;
                tick_ok   = tick_at_edge;
                cap_d     = cur_data;
                cap_fe    = cur_ferr;
                cap_pe    = cur_perr;
                grab_next = 1'b1;
            end
            v_before = cur_valid;
        end
        drive_rx(s, 1'b1);
    endtask

    typedef struct {
        logic       s;
        logic [7:0] data;
        logic       par_bit;
        logic       stop_bit;
        logic [7:0] exp_data;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic       rose, tick_ok, cfe, cpe, vn;
        logic [7:0] cd;
        int         busy_cnt;
        int         valid_seen;
        int         ovr_base;

        vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};

        reset = 1'b1; rx0 = 1'b1; rx1 = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_valid0", {30'd0, v1, v0}, 32'd0);
        check("reset_data0", {16'd0, d1, d0}, 32'd0);
        check("reset_ferr", {30'd0, fe1, fe0}, 32'd0);
        check("reset_perr", {30'd0, pe1, pe0}, 32'd0);
        check("reset_overrun", {30'd0, ov1, ov0}, 32'd0);
        check("reset_busy", {30'd0, b1, b0}, 32'd0);
        repeat (40) @(negedge clk);
        check("idle_ticks_no_busy", {30'd0, b1, b0}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].s, vecs[i].data, vecs[i].s, vecs[i].par_bit, vecs[i].stop_bit,
                       rose, tick_ok, cd, cfe, cpe, vn);
            check($sformatf("v%0d_valid_rose", i), {31'd0, rose}, 32'd1);
            check($sformatf("v%0d_tick_latency", i), {31'd0, tick_ok}, 32'd1);
            check($sformatf("v%0d_data", i), {24'd0, cd}, {24'd0, vecs[i].exp_data});
            check($sformatf("v%0d_frame_err", i), {31'd0, cfe}, {31'd0, vecs[i].exp_fe});
            check($sformatf("v%0d_parity_err", i), {31'd0, cpe}, {31'd0, vecs[i].exp_pe});
            check($sformatf("v%0d_valid_drop", i), {31'd0, vn}, 32'd0);
            repeat (100) @(negedge clk);
            check($sformatf("v%0d_busy_idle", i), {31'd0, cur_busy}, 32'd0);
        end

        // Short low glitch: rejected at mid-start after exactly 8 ticks of busy.
        sel = 1'b0; busy_cnt = 0; valid_seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (i == 0)  rx0 = 1'b0;
            if (i == 20) rx0 = 1'b1;
            @(negedge clk);
            if (b0) busy_cnt++;
            if (v0) valid_seen++;
        end
        check("glitch_busy_cycles", busy_cnt, 32'd32);
        check("glitch_no_valid", valid_seen, 32'd0);
        check("glitch_busy_end", {31'd0, b0}, 32'd0);

        // Back-to-back frames into a stalled buffer.
        rdy0 = 1'b0;
        ovr_base = ovr_cnt0;
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, rose, tick_ok, cd, cfe, cpe, vn);
        check("ovr_first_rose", {31'd0, rose}, 32'd1);
        check("ovr_first_data", {24'd0, cd}, 32'h11);
        check("ovr_held_valid", {31'd0, vn}, 32'd1);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, rose, tick_ok, cd, cfe, cpe, vn);
        @(negedge clk);
        check("ovr_data_kept", {24'd0, d0}, 32'h11);
        check("ovr_valid_kept", {31'd0, v0}, 32'd1);
        check("ovr_ferr_kept", {31'd0, fe0}, 32'd0);
        check("ovr_pulse_count", ovr_cnt0 - ovr_base, 32'd1);
        rdy0 = 1'b1;
        @(negedge clk);
        check("ovr_drain_valid", {31'd0, v0}, 32'd0);

        // Reset in the middle of data bit 4 of 0xFF.
        repeat (50) @(negedge clk);
        ovr_base = ovr_cnt0;
        rx0 = 1'b0;
        repeat (64) @(negedge clk);
        rx0 = 1'b1;
        repeat (4 * 64 + 32) @(negedge clk);
        check("rst_mid_busy", {31'd0, b0}, 32'd1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_busy_cleared", {31'd0, b0}, 32'd0);
        valid_seen = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (v0) valid_seen++;
        end
        check("rst_mid_no_delivery", valid_seen, 32'd0);
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, rose, tick_ok, cd, cfe, cpe, vn);
        check("rst_after_rose", {31'd0, rose}, 32'd1);
        check("rst_after_data", {24'd0, cd}, 32'h5A);
        check("rst_after_ferr", {31'd0, cfe}, 32'd0);
        check("rst_no_overrun", ovr_cnt0 - ovr_base, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side sequencer for the UART: consumes the 16x oversampling tick from the baud clock generator and the serial line.
- Centre-samples each bit and assembles frames: start, DATA_BITS LSB-first, optional parity, 1 stop.
- Delivers each byte through a one-entry valid/ready output buffer with error and overrun status.
- Sits between uart_generator_clock (sample_clk as tick) and the host-side register/FIFO logic.

Parameters:
- DATA_BITS, 8, payload bits per frame (5..9)
- SAMPLE, 16, sample ticks per bit (even, >=4)
- PARITY_EN, 0, 1 = a parity bit follows the data
- PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored if PARITY_EN=0)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sample_tick  in  1  one-clk pulse at SAMPLE x baud
- rx  in  1  asynchronous serial input, idle high
- rx_data  out  DATA_BITS  received payload, valid while rx_valid=1
- rx_valid  out  1  output buffer holds a frame
- rx_ready  in  1  consumer accepts when rx_valid&rx_ready
- frame_err  out  1  stop bit sampled 0; qualified by rx_valid
- parity_err  out  1  parity mismatch; qualified by rx_valid; 0 if PARITY_EN=0
- overrun  out  1  one-clk pulse: completed frame dropped
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: clk and reset only; reset is synchronous and active-high. State=IDLE, counters=0, rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0. Both synchronizer flops reset to 1.
- Reset asserted mid-frame aborts the frame. Nothing is delivered and overrun is not pulsed.
- rx passes through a 2-FF synchronizer to give rx_s (2 clk latency). All FSM decisions use rx_s.
- FSM advances only on cycles with sample_tick=1. tick_cnt is $clog2(SAMPLE) bits; bit_cnt is $clog2(DATA_BITS) bits.
- IDLE: on a tick with rx_s=0, go to START with tick_cnt=0.
- START: on each tick, tick_cnt++.
  - At tick_cnt==SAMPLE/2-1 with rx_s=0: go to DATA, tick_cnt=0, bit_cnt=0.
  - At the same point with rx_s=1: glitch rejected, return to IDLE, no status.
- DATA: at tick_cnt==SAMPLE-1, shift rx_s into the MSB of the shift register (LSB first on the line) and set tick_cnt=0.
  - After bit_cnt==DATA_BITS-1: go to PARITY if PARITY_EN, else STOP. Otherwise bit_cnt++.
- PARITY: at tick_cnt==SAMPLE-1, store perr = (^shift ^ rx_s) != PARITY_ODD, then go to STOP.
- STOP: at tick_cnt==SAMPLE-1, commit the frame (ferr = ~rx_s) and go to IDLE on the same tick.
  - Return to IDLE is at mid-stop, so a back-to-back start bit is caught.
- Commit, registered, visible the next clk:
  - If the buffer is empty, or rx_valid&rx_ready in the commit cycle: load rx_data, frame_err, parity_err and set rx_valid=1.
  - Otherwise: keep the old contents and pulse overrun for 1 clk.
- Buffer: rx_valid clears on the cycle after rx_valid&rx_ready with no simultaneous commit. rx_data and the error flags are stable while rx_valid=1.
- Frames with errors are still delivered; the flags describe that frame only.
- Latency: rx_valid rises 1 clk after the tick at mid-stop-bit.
- busy = (state != IDLE).
- A sample_tick present while in IDLE with rx_s=1 has no effect.

Decomposition:
- uart_pkg:
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - Shared constants: default SAMPLE=16, default DATA_BITS=8.
- Sub-module uart_sync: parameterised 2-FF synchronizer with reset value 1, reusable by other UART blocks.

Test Plan (tick every 4 clk, SAMPLE=16, DATA_BITS=8, rx_ready=1 unless stated):
- Send 0xA5, 8N1, good stop -> rx_data=0xA5, rx_valid 1 clk after the mid-stop tick, frame_err=0, parity_err=0, busy back to 0.
- 0-pulse of 5 ticks on idle rx -> returns to IDLE at mid-start, no rx_valid, busy high for about 8 ticks only.
- Send 0x3C with stop bit driven 0 -> rx_data=0x3C, rx_valid=1, frame_err=1.
- PARITY_EN=1, PARITY_ODD=0: 0x07 with parity=1 -> parity_err=0. Same byte with parity=0 -> parity_err=1.
- rx_ready=0, frames 0x11 then 0x22 back-to-back -> rx_data stays 0x11 and overrun pulses once at the second commit. Then raise rx_ready -> rx_valid drops next clk.
- Assert reset during DATA bit 4 of 0xFF, release, send 0x5A -> no delivery for 0xFF, rx_data=0x5A, no overrun.
